// File: rtl/wb_stage.sv
// ============================================================================
// wb_stage : RISC-V writeback stage (load extraction, regfile write, instret)
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_stage #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_reg_we,
  input  logic [4:0]           in_rd,
  input  logic                 in_mem_to_reg,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_addr_lo,
  input  logic [DWIDTH-1:0]    in_alu_result,
  input  logic                 dmem_rvalid,
  input  logic [DWIDTH-1:0]    dmem_rdata,
  output logic                 reg_we,
  output logic [4:0]           addr_rd,
  output logic [DWIDTH-1:0]    data_rd,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 err_rvalid,
  output logic                 err_funct3
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t      state;
  logic [4:0]  ld_rd;
  logic        ld_we;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;

  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DWIDTH-1:0] load_data;
  logic              funct3_bad;

  assign in_ready = (state == IDLE);

  // Halfword lane uses addr_lo[1] only; a misaligned addr_lo[0] is ignored.
  always_comb begin
    sel_byte   = 8'h00;
    sel_half   = ld_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data  = dmem_rdata;
    funct3_bad = 1'b0;
    case (ld_addr_lo)
      2'd0:    sel_byte = dmem_rdata[7:0];
      2'd1:    sel_byte = dmem_rdata[15:8];
      2'd2:    sel_byte = dmem_rdata[23:16];
      default: sel_byte = dmem_rdata[31:24];
    endcase
    case (ld_funct3)
      F3_LB:   load_data = {{(DWIDTH-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  load_data = {{(DWIDTH-8){1'b0}}, sel_byte};
      F3_LH:   load_data = {{(DWIDTH-16){sel_half[15]}}, sel_half};
      F3_LHU:  load_data = {{(DWIDTH-16){1'b0}}, sel_half};
      F3_LW:   load_data = dmem_rdata;
      default: begin
        load_data  = dmem_rdata;
        funct3_bad = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      reg_we     <= 1'b0;
      addr_rd    <= 5'd0;
      data_rd    <= '0;
      instret    <= '0;
      err_rvalid <= 1'b0;
      err_funct3 <= 1'b0;
      ld_rd      <= 5'd0;
      ld_we      <= 1'b0;
      ld_funct3  <= 3'd0;
      ld_addr_lo <= 2'd0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        IDLE: begin
          if (dmem_rvalid) err_rvalid <= 1'b1;
          if (in_valid) begin
            if (in_mem_to_reg) begin
              ld_rd      <= in_rd;
              ld_we      <= in_reg_we;
              ld_funct3  <= in_funct3;
              ld_addr_lo <= in_addr_lo;
              state      <= WAIT_LOAD;
            end else begin
              reg_we  <= in_reg_we && (in_rd != 5'd0);
              addr_rd <= in_rd;
              data_rd <= in_alu_result;
              instret <= instret + CNT_ONE;
            end
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            reg_we  <= ld_we && (ld_rd != 5'd0);
            addr_rd <= ld_rd;
            data_rd <= load_data;
            instret <= instret + CNT_ONE;
            if (funct3_bad) err_funct3 <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// Scoreboarded bench for wb_stage; a narrow instret (4 bits) makes wrap reachable.
`timescale 1ns/1ps
`default_nettype none

module tb_wb_stage;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic          we;
    logic [4:0]    rd;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_reg_we = 1'b0;
  logic [4:0]    in_rd = 5'd0;
  logic          in_mem_to_reg = 1'b0;
  logic [2:0]    in_funct3 = 3'd0;
  logic [1:0]    in_addr_lo = 2'd0;
  logic [DW-1:0] in_alu_result = '0;
  logic          dmem_rvalid = 1'b0;
  logic [DW-1:0] dmem_rdata = '0;
  logic          reg_we;
  logic [4:0]    addr_rd;
  logic [DW-1:0] data_rd;
  logic [CW-1:0] instret;
  logic          err_rvalid;
  logic          err_funct3;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [CW-1:0] exp_cnt = '0;

  wb_stage #(.DWIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_we(in_reg_we), .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .reg_we(reg_we), .addr_rd(addr_rd), .data_rd(data_rd),
    .instret(instret), .err_rvalid(err_rvalid), .err_funct3(err_funct3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Monitor: every retirement (instret change) pops one expected write.
  initial begin
    logic [CW-1:0] last;
    exp_t e, got;
    last = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last = '0;
      end else if (instret != last) begin
        last = instret;
        got  = '{we: reg_we, rd: addr_rd, data: data_rd, cnt: instret};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL retire_unexpected: got we=%0b rd=%0d data=%h cnt=%0d, none expected",
                   reg_we, addr_rd, data_rd, instret);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL retire: got we=%0b rd=%0d data=%h cnt=%0d, expected we=%0b rd=%0d data=%h cnt=%0d",
                     got.we, got.rd, got.data, got.cnt, e.we, e.rd, e.data, e.cnt);
          end
        end
      end else if (reg_we) begin
        checks++;
        errors++;
        $display("FAIL spurious_we: reg_we=1 rd=%0d without retirement, expected reg_we=0", addr_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic alu_op(input logic we, input logic [4:0] rd, input logic [DW-1:0] val);
    in_valid = 1'b1; in_mem_to_reg = 1'b0; in_reg_we = we; in_rd = rd; in_alu_result = val;
    exp_cnt = exp_cnt + 1'b1;
    q.push_back('{we: we && (rd != 0), rd: rd, data: val, cnt: exp_cnt});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                         input logic [DW-1:0] rdata, input int waits, input logic [DW-1:0] exp_data);
    in_valid = 1'b1; in_mem_to_reg = 1'b1; in_reg_we = 1'b1; in_rd = rd;
    in_funct3 = f3; in_addr_lo = alo; in_alu_result = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0; in_mem_to_reg = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check("in_ready_wait", {31'd0, in_ready}, 32'd0);
      tick();
    end
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    exp_cnt = exp_cnt + 1'b1;
    q.push_back('{we: (rd != 0), rd: rd, data: exp_data, cnt: exp_cnt});
    tick();
    dmem_rvalid = 1'b0;
    check("in_ready_after_load", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    do_reset();
    check("rst_reg_we", {31'd0, reg_we}, 32'd0);
    check("rst_addr_rd", {27'd0, addr_rd}, 32'd0);
    check("rst_data_rd", data_rd, 32'd0);
    check("rst_instret", {28'd0, instret}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_errs", {30'd0, err_rvalid, err_funct3}, 32'd0);

    // 1: simple ALU write
    alu_op(1'b1, 5'd5, 32'h0000_1234);
    tick();

    // 2: byte loads
    load_op(5'd3, 3'b000, 2'd2, 32'h0080_0000, 3, 32'hFFFF_FF80);
    load_op(5'd3, 3'b100, 2'd2, 32'h0080_0000, 3, 32'h0000_0080);
    // 3: halfword / word loads
    load_op(5'd4, 3'b001, 2'd2, 32'h8001_7FFF, 1, 32'hFFFF_8001);
    load_op(5'd4, 3'b101, 2'd2, 32'h8001_7FFF, 1, 32'h0000_8001);
    load_op(5'd4, 3'b001, 2'd3, 32'h8001_7FFF, 2, 32'hFFFF_8001);
    load_op(5'd6, 3'b010, 2'd1, 32'h8001_7FFF, 1, 32'h8001_7FFF);
    load_op(5'd7, 3'b000, 2'd3, 32'h7F00_0000, 1, 32'h0000_007F);
    load_op(5'd7, 3'b001, 2'd0, 32'h8001_7FFF, 1, 32'h0000_7FFF);
    check("err_funct3_legal", {31'd0, err_funct3}, 32'd0);
    tick();

    // 4: back-to-back, third targets x0
    do_reset();
    alu_op(1'b1, 5'd1, 32'h1111_0001);
    alu_op(1'b1, 5'd2, 32'h2222_0002);
    alu_op(1'b1, 5'd0, 32'h3333_0003);
    alu_op(1'b1, 5'd4, 32'h4444_0004);
    alu_op(1'b1, 5'd5, 32'h5555_0005);
    tick();
    check("b2b_instret", {28'd0, instret}, 32'd5);
    check("b2b_err_rvalid", {31'd0, err_rvalid}, 32'd0);

    // 5: stray rvalid in IDLE, illegal funct3 load
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    check("stray_err_rvalid", {31'd0, err_rvalid}, 32'd1);
    check("stray_instret", {28'd0, instret}, 32'd5);
    load_op(5'd9, 3'b011, 2'd1, 32'h89AB_CDEF, 2, 32'h89AB_CDEF);
    tick();
    check("err_funct3_set", {31'd0, err_funct3}, 32'd1);
    check("err_rvalid_sticky", {31'd0, err_rvalid}, 32'd1);

    // 6: reset during WAIT_LOAD, late rvalid, then counter wrap
    do_reset();
    in_valid = 1'b1; in_mem_to_reg = 1'b1; in_reg_we = 1'b1; in_rd = 5'd8; in_funct3 = 3'b010;
    tick();
    in_valid = 1'b0; in_mem_to_reg = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    tick();
    check("late_reg_we", {31'd0, reg_we}, 32'd0);
    check("late_instret", {28'd0, instret}, 32'd0);
    check("late_err_rvalid", {31'd0, err_rvalid}, 32'd1);
    check("late_err_funct3", {31'd0, err_funct3}, 32'd0);
    for (int i = 0; i < 15; i++) alu_op(1'b1, 5'd10, 32'h0000_0100 + i);
    tick();
    check("instret_max", {28'd0, instret}, 32'd15);
    alu_op(1'b1, 5'd11, 32'hFFFF_0000);
    tick();
    check("instret_wrap", {28'd0, instret}, 32'd0);

    tick();
    tick();
    check("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage of the RISC-V core. It accepts completed instructions from the memory stage and, for loads, waits for the data-memory response. It extracts and sign/zero-extends the loaded byte, halfword or word. It drives the register-file write port of the decode stage: reg_we, addr_rd and data_rd. It also keeps a retired-instruction counter and sticky protocol-error flags.

Parameters:
DWIDTH, 32, data/register width (only 32 supported)
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can accept; handshake completes when in_valid && in_ready
in_reg_we  input  1  instruction writes rd
in_rd  input  5  destination register index
in_mem_to_reg  input  1  instruction is a load (result comes from dmem)
in_funct3  input  3  load size/sign (RISC-V funct3)
in_addr_lo  input  2  low two bits of load byte address
in_alu_result  input  DWIDTH  result for non-load instructions
dmem_rvalid  input  1  load data valid this cycle
dmem_rdata  input  DWIDTH  raw 32-bit aligned memory word
reg_we  output  1  register-file write enable (one-cycle pulse)
addr_rd  output  5  register-file write address
data_rd  output  DWIDTH  register-file write data
instret  output  CNT_WIDTH  retired-instruction count
err_rvalid  output  1  sticky: dmem_rvalid seen while no load pending
err_funct3  output  1  sticky: illegal load funct3 retired

Behaviour:
- Reset (rst=0, async): state=IDLE; reg_we=0; addr_rd=0; data_rd=0; instret=0; err_rvalid=0; err_funct3=0; pending load discarded.
- States: IDLE and WAIT_LOAD. in_ready = (state==IDLE).
- IDLE, accept with in_mem_to_reg=0:
  - Next cycle reg_we = in_reg_we && (in_rd!=0), addr_rd=in_rd, data_rd=in_alu_result.
  - Latency 1 cycle; instret increments at the same edge.
  - Back-to-back accepts allowed every cycle.
- IDLE, accept with in_mem_to_reg=1: capture rd, reg_we flag, funct3 and addr_lo; go to WAIT_LOAD. No write that cycle.
- WAIT_LOAD, dmem_rvalid=0: hold; in_ready=0.
- WAIT_LOAD, dmem_rvalid=1: next cycle reg_we pulses (rd!=0 and captured reg_we), with extracted data. instret increments. Return to IDLE, so in_ready=1 in that next cycle.
- dmem_rvalid in IDLE: ignored, no write, err_rvalid set. The memory never answers in the acceptance cycle; load latency is at least 1.
- Load extraction, byte lane selected by addr_lo:
  - 000 LB: byte[addr_lo], sign-extended.
  - 100 LBU: byte[addr_lo], zero-extended.
  - 001 LH: halfword[addr_lo[1]], sign-extended.
  - 101 LHU: halfword[addr_lo[1]], zero-extended.
  - 010 LW: full word; addr_lo ignored.
  - Other codes: full word, and err_funct3 set when the load retires.
- Misaligned halfword (addr_lo[0]=1): addr_lo[0] ignored, no trap.
- Writes to x0 are suppressed: reg_we=0, but addr_rd/data_rd still update and instret still counts.
- reg_we is high for exactly one cycle per writing instruction; addr_rd/data_rd hold their last value when reg_we=0.
- instret wraps from all-ones to 0.
- Error flags clear only on reset.
- Reset asserted in WAIT_LOAD: load dropped, no write. A late dmem_rvalid after reset release sets err_rvalid.

Test Plan:
1. Reset, then accept ADD-like {rd=5, alu=0x0000_1234, reg_we=1} -> next cycle reg_we=1, addr_rd=5, data_rd=0x1234, instret=1.
2. Load LB rd=3, addr_lo=2, rdata=0x00_80_00_00 after 3 wait cycles -> in_ready=0 during wait; one cycle after rvalid data_rd=0xFFFF_FF80, reg_we=1; LBU same -> 0x0000_0080.
3. LH/LHU addr_lo=2, rdata=0x8001_7FFF -> 0xFFFF_8001 / 0x0000_8001; LH addr_lo=3 -> same as addr_lo=2; LW -> 0x8001_7FFF.
4. Five back-to-back non-loads, in_rd=0 for the third -> reg_we pattern 1,1,0,1,1 on consecutive cycles; instret=5.
5. dmem_rvalid pulse in IDLE -> no write, err_rvalid=1 and stays 1; load with funct3=011 -> full word written, err_funct3=1.
6. Assert rst during WAIT_LOAD, release, then pulse dmem_rvalid -> no reg_we, instret=0, err_rvalid=1; preload instret to all-ones and retire one -> instret=0.
